// File: rtl/rc4_prga_decryptor.sv
// RC4 keystream generator (PRGA) that XOR-decrypts MSG_LEN ROM bytes into the output RAM.
// Optional macro ABORT_ON_INVALID_EN: stop early on the first byte that is not a-z or space.
module rc4_prga_decryptor #(
  parameter int MSG_LEN  = 32,
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       decrypt_done,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  output logic       s_wren,
  input  logic [7:0] s_q,
  output logic [4:0] enc_address,
  input  logic [7:0] enc_q,
  output logic [4:0] dec_address,
  output logic [7:0] dec_data,
  output logic       dec_wren,
  output logic       invalid_flag
);

  typedef enum logic [3:0] {
    IDLE, INC_I, RD_SI, J_UPD, RD_SJ, WR_SI, WR_SJ, RD_F, RD_ENC, WR_OUT, NEXT, DONE
  } state_t;

  localparam int PW = $clog2(MEM_WAIT + 2);
  localparam logic [PW-1:0] LAST_PHASE = PW'(MEM_WAIT + 1);
  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

  state_t        state;
  logic [PW-1:0] phase;
  logic [7:0]    i, j, k, si, sj, f;
  logic          s_wren_reg, dec_wren_reg;
  logic          advance;

  assign advance  = start && !decrypt_done;
  // Write strobes are held in registers; a low start masks them so a paused cycle never writes.
  assign s_wren   = s_wren_reg & start;
  assign dec_wren = dec_wren_reg & start;

`ifdef ABORT_ON_INVALID_EN
  function automatic logic is_text(input logic [7:0] x);
    return (x >= 8'h61 && x <= 8'h7a) || x == 8'h20;
  endfunction
  logic invalid_reg;
  assign invalid_flag = invalid_reg;
`else
  assign invalid_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      phase        <= '0;
      i            <= '0;
      j            <= '0;
      k            <= '0;
      si           <= '0;
      sj           <= '0;
      f            <= '0;
      s_address    <= '0;
      s_data       <= '0;
      s_wren_reg   <= 1'b0;
      enc_address  <= '0;
      dec_address  <= '0;
      dec_data     <= '0;
      dec_wren_reg <= 1'b0;
      decrypt_done <= 1'b0;
`ifdef ABORT_ON_INVALID_EN
      invalid_reg  <= 1'b0;
`endif
    end else if (advance) begin
      case (state)
        IDLE: state <= INC_I;
        INC_I: begin
          i     <= i + 8'd1;
          phase <= '0;
          state <= RD_SI;
        end
        RD_SI: begin
          if (phase == '0) s_address <= i;
          if (phase == LAST_PHASE) begin
            si    <= s_q;
            phase <= '0;
            state <= J_UPD;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        J_UPD: begin
          j     <= j + si;
          state <= RD_SJ;
        end
        RD_SJ: begin
          if (phase == '0) s_address <= j;
          if (phase == LAST_PHASE) begin
            sj         <= s_q;
            s_address  <= i;
            s_data     <= s_q;
            s_wren_reg <= 1'b1;
            phase      <= '0;
            state      <= WR_SI;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        // When i==j both writes carry the same value, so the swap degenerates correctly.
        WR_SI: begin
          s_address <= j;
          s_data    <= si;
          state     <= WR_SJ;
        end
        WR_SJ: begin
          s_wren_reg <= 1'b0;
          state      <= RD_F;
        end
        RD_F: begin
          if (phase == '0) s_address <= si + sj;
          if (phase == LAST_PHASE) begin
            f     <= s_q;
            phase <= '0;
            state <= RD_ENC;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        RD_ENC: begin
          if (phase == '0) enc_address <= k[4:0];
          if (phase == LAST_PHASE) begin
            dec_address  <= k[4:0];
            dec_data     <= f ^ enc_q;
            dec_wren_reg <= 1'b1;
            phase        <= '0;
            state        <= WR_OUT;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        WR_OUT: begin
          dec_wren_reg <= 1'b0;
          state        <= NEXT;
`ifdef ABORT_ON_INVALID_EN
          if (!is_text(dec_data)) begin
            invalid_reg  <= 1'b1;
            decrypt_done <= 1'b1;
            state        <= DONE;
          end
`endif
        end
        NEXT: begin
          if (k == LAST_K) begin
            state <= DONE;
          end else begin
            k     <= k + 8'd1;
            state <= INC_I;
          end
        end
        DONE: decrypt_done <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_prga_decryptor.sv
// Randomized bench for rc4_prga_decryptor with behavioural RC4 reference and memory models.
module tb_rc4_prga_decryptor;

  localparam int MSG_LEN  = 32;
  localparam int MEM_WAIT = 2;

  logic       clk = 1'b0;
  logic       reset, start, decrypt_done;
  logic [7:0] s_address, s_data, s_q;
  logic       s_wren;
  logic [4:0] enc_address, dec_address;
  logic [7:0] enc_q, dec_data;
  logic       dec_wren, invalid_flag;

  rc4_prga_decryptor #(.MSG_LEN(MSG_LEN), .MEM_WAIT(MEM_WAIT)) dut (
    .clk(clk), .reset(reset), .start(start), .decrypt_done(decrypt_done),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .enc_address(enc_address), .enc_q(enc_q),
    .dec_address(dec_address), .dec_data(dec_data), .dec_wren(dec_wren),
    .invalid_flag(invalid_flag)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem[256];
  logic [7:0] s_init[256];
  logic [7:0] enc_rom[32];
  logic [7:0] dec_mem[32];
  logic [7:0] pt[32];
  logic       load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
      for (int x = 0; x < 32; x++) dec_mem[x] <= 8'hEE;
    end else begin
      if (s_wren) s_mem[s_address] <= s_data;
      if (dec_wren) dec_mem[dec_address] <= dec_data;
    end
    s_q   <= s_mem[s_address];
    enc_q <= enc_rom[enc_address];
  end

  int   wren_viol = 0;
  logic prev_s = 1'b0, prev_s2 = 1'b0, prev_d = 1'b0;
  always @(negedge clk) begin
    if (s_wren && dec_wren) wren_viol++;
    if (dec_wren && prev_d) wren_viol++;
    if (s_wren && prev_s && prev_s2) wren_viol++;
    prev_s2 = prev_s;
    prev_s  = s_wren;
    prev_d  = dec_wren;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: textbook RC4 PRGA on plain arrays.
  logic [7:0] m_s[256];
  logic [7:0] m_dec[32];
  int         m_n;
  bit         m_inval;

  task automatic ref_model();
    int ii, jj;
    logic [7:0] t, ks;
    for (int x = 0; x < 256; x++) m_s[x] = s_init[x];
    for (int x = 0; x < 32; x++) m_dec[x] = 8'hEE;
    ii = 0; jj = 0; m_n = 0; m_inval = 0;
    for (int b = 0; b < MSG_LEN; b++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(m_s[ii])) % 256;
      t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
      ks = m_s[(int'(m_s[ii]) + int'(m_s[jj])) % 256];
      m_dec[b] = ks ^ enc_rom[b];
      m_n = b + 1;
`ifdef ABORT_ON_INVALID_EN
      if (!((m_dec[b] >= 8'h61 && m_dec[b] <= 8'h7a) || m_dec[b] == 8'h20)) begin
        m_inval = 1;
        break;
      end
`endif
    end
  endtask

  task automatic gen_valid_enc();
    logic [7:0] ss[256];
    logic [7:0] t;
    int ii, jj;
    for (int x = 0; x < 256; x++) ss[x] = s_init[x];
    ii = 0; jj = 0;
    for (int b = 0; b < 32; b++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(ss[ii])) % 256;
      t = ss[ii]; ss[ii] = ss[jj]; ss[jj] = t;
      pt[b] = ($urandom_range(5, 0) == 0) ? 8'h20 : 8'(8'h61 + $urandom_range(25, 0));
      enc_rom[b] = ss[(int'(ss[ii]) + int'(ss[jj])) % 256] ^ pt[b];
    end
  endtask

  task automatic rand_perm();
    int r;
    logic [7:0] t;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(x, 0);
      t = s_init[x]; s_init[x] = s_init[r]; s_init[r] = t;
    end
  endtask

  task automatic rand_enc();
    for (int x = 0; x < 32; x++) enc_rom[x] = 8'($urandom_range(255, 0));
  endtask

  task automatic load_and_reset();
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, decrypt_done, 0);
    check({tag, "_s_wren"}, s_wren, 0);
    check({tag, "_dec_wren"}, dec_wren, 0);
    check({tag, "_s_addr"}, s_address, 0);
    check({tag, "_enc_addr"}, enc_address, 0);
    check({tag, "_dec_addr"}, dec_address, 0);
    check({tag, "_inval"}, invalid_flag, 0);
  endtask

  // Runs with start high; optional 10-cycle pause beginning after edge pause_edge.
  task automatic run_msg(input int pause_edge, output int done_edge);
    int edge_n;
    int frz;
    logic [33:0] snap;
    edge_n = 0;
    done_edge = -1;
    @(negedge clk); start = 1'b1;
    while (edge_n < 3000 && done_edge < 0) begin
      @(posedge clk); #1; edge_n++;
      if (decrypt_done) begin
        done_edge = edge_n;
      end else if (edge_n == pause_edge) begin
        start = 1'b0;
        snap = {s_address, s_data, enc_address, dec_address, dec_data};
        frz = 0;
        repeat (10) begin
          @(posedge clk); #1; edge_n++;
          if ({s_address, s_data, enc_address, dec_address, dec_data} !== snap) frz++;
          if (s_wren || dec_wren || decrypt_done) frz++;
        end
        start = 1'b1;
        check("pause_frozen", frz, 0);
      end
    end
    check("done_seen", done_edge >= 0, 1);
    @(negedge clk); start = 1'b0;
  endtask

  task automatic verify(input string name, input int done_edge, input int extra);
    int exp_edge;
    ref_model();
    exp_edge = m_inval ? 22 * m_n : 2 + 22 * MSG_LEN;
    check({name, "_done_edge"}, done_edge, exp_edge + extra);
    check({name, "_inval"}, invalid_flag, m_inval);
    for (int x = 0; x < 32; x++) check($sformatf("%s_dec%0d", name, x), dec_mem[x], m_dec[x]);
    for (int x = 0; x < 256; x++) check($sformatf("%s_s%0d", name, x), s_mem[x], m_s[x]);
    $display("test %s: bytes=%0d inval=%0d done_edge=%0d checks=%0d errors=%0d",
             name, m_n, m_inval, done_edge, n_checks, n_errors);
  endtask

  initial begin
    int de;
    int jk;
    logic [7:0] t;
    logic [7:0] key[3];
    reset = 1'b1;
    start = 1'b0;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    for (int x = 0; x < 32; x++) enc_rom[x] = 8'h00;
    load_and_reset();
    #1;
    check_reset_outputs("rst");

    // Identity S, all-zero ciphertext: output is the raw keystream.
    run_msg(-1, de);
`ifndef ABORT_ON_INVALID_EN
    check("ident_dec0", dec_mem[0], 8'h02);
    check("ident_dec1", dec_mem[1], 8'h05);
    check("ident_dec2", dec_mem[2], 8'h07);
    check("ident_done706", de, 706);
`endif
    verify("ident_zero", de, 0);

    // Identity S, first plaintext byte 'a', second byte 0x60.
    rand_enc();
    enc_rom[0] = 8'h63;
    enc_rom[1] = 8'h65;
    load_and_reset();
    run_msg(-1, de);
    check("ident_a_dec0", dec_mem[0], 8'h61);
`ifdef ABORT_ON_INVALID_EN
    check("abort_flag", invalid_flag, 1);
    check("abort_edge", de, 44);
    check("abort_dec2", dec_mem[2], 8'hEE);
`endif
    verify("ident_a", de, 0);

    // S from KSA with key 00 02 49; ciphertext built from random text.
    key[0] = 8'h00; key[1] = 8'h02; key[2] = 8'h49;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    jk = 0;
    for (int x = 0; x < 256; x++) begin
      jk = (jk + int'(s_init[x]) + int'(key[x % 3])) % 256;
      t = s_init[x]; s_init[x] = s_init[jk]; s_init[jk] = t;
    end
    gen_valid_enc();
    load_and_reset();
    run_msg(-1, de);
    for (int x = 0; x < 32; x++) check($sformatf("ksa_pt%0d", x), dec_mem[x], pt[x]);
    verify("ksa", de, 0);

    // Pause for 10 cycles inside RD_SJ of byte 3.
    rand_perm();
    gen_valid_enc();
    load_and_reset();
    run_msg(2 + 22 * 3 + 6, de);
    verify("pause", de, 10);

    // Reset during byte 5, then a fresh run.
    rand_perm();
    gen_valid_enc();
    load_and_reset();
    @(negedge clk); start = 1'b1;
    repeat (2 + 22 * 5 + 8) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    start = 1'b0;
    rand_perm();
    gen_valid_enc();
    load_and_reset();
    run_msg(-1, de);
    verify("after_rst", de, 0);

    // Fully random ciphertext and permutations.
    for (int r = 0; r < 3; r++) begin
      rand_perm();
      rand_enc();
      load_and_reset();
      run_msg(-1, de);
      verify($sformatf("rand%0d", r), de, 0);
    end

    check("wren_rules", wren_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rc4_prga_decryptor.md
Name: rc4_prga_decryptor

Overview:
- RC4 keystream generation (PRGA) and XOR decrypt stage.
- Sits directly upstream of the key-validity checker. The KSA stage has already left the permuted S array in s_memory (256x8).
- For each message byte k, the block generates a keystream byte, XORs it with encrypted ROM byte k, and writes the result to Decrypted_Message RAM word k.
- The checker then reads that RAM after this block raises done.

Parameters:
- MSG_LEN, 32, number of message bytes processed (1..256). Addresses are 8 bits internally; output address is the low 5 bits.
- MEM_WAIT, 2, idle cycles between driving a RAM/ROM address and sampling q (matches existing on-chip memory timing).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level enable; the block advances only while high.
- decrypt_done  output  1  sticky completion flag.
- s_address  output  8  s_memory address.
- s_data  output  8  s_memory write data.
- s_wren  output  1  s_memory write enable.
- s_q  input  8  s_memory read data.
- enc_address  output  5  encrypted-message ROM address.
- enc_q  input  8  ROM read data.
- dec_address  output  5  Decrypted_Message RAM address.
- dec_data  output  8  RAM write data.
- dec_wren  output  1  RAM write enable.
- invalid_flag  output  1  early-abort indicator (see Optional Feature).

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset effect: i=0, j=0, k=0; all addresses/data = 0; s_wren = dec_wren = 0; decrypt_done = 0; invalid_flag = 0; state = IDLE.
- Reset wins over start on the same edge. Reset mid-operation abandons the message; partially written RAM/S contents are not restored.
- Pause rule: a state advances only when start = 1 and decrypt_done = 0. If start is low, the state and registers hold, and both wren outputs are forced to 0 that cycle.
- All arithmetic is 8-bit modulo 256.
- Read macro (RD_x): one cycle driving the address, then MEM_WAIT wait cycles, then one cycle capturing q into a register. Total 2+MEM_WAIT cycles.
- State sequence:
  - IDLE: go to INC_I.
  - INC_I: i <= i+1.
  - RD_SI: read s[i] into si.
  - J_UPD: j <= j+si.
  - RD_SJ: read s[j] into sj.
  - WR_SI: s_address=i, s_data=sj, s_wren=1 for exactly one cycle.
  - WR_SJ: s_address=j, s_data=si, s_wren=1 for exactly one cycle.
  - RD_F: read s[si+sj] into f.
  - RD_ENC: enc_address=k; read into e.
  - WR_OUT: dec_address=k, dec_data=f^e, dec_wren=1 for exactly one cycle.
  - NEXT: if k==MSG_LEN-1, go to DONE; else k <= k+1 and go to INC_I.
  - DONE: decrypt_done <= 1 and hold. Leave only via reset.
- Cycle count: 22 cycles per byte at MEM_WAIT=2. decrypt_done is first high on edge 1+MSG_LEN*22+1 = 706 after start rises, provided start stays high.
- Aliasing: when i==j, the two writes store the same value twice. The result must equal the standard RC4 result, with no corruption.
- k wrap: with MSG_LEN=256, k stops at 255 and does not wrap.
- Write enables: never high outside the WR_* states.

Optional Feature:
- Macro: ABORT_ON_INVALID_EN.
- Defined: in WR_OUT, if f^e is not in 0x61..0x7A and not 0x20:
  - The byte is still written.
  - invalid_flag <= 1 and decrypt_done <= 1 on the next edge (skipping NEXT).
  - The key-search controller can then skip the checker for that key.
  - invalid_flag clears only on reset.
- Not defined: invalid_flag is tied to 0, and all MSG_LEN bytes are always processed.

Test Plan:
- Identity S (s[x]=x), enc all 0x00, start held high:
  - dec[0]=0x02, dec[1]=0x05, dec[2]=0x07.
  - After byte 0: s[1]=1 (i==j alias, unchanged). After byte 1: s[2]=3, s[3]=2.
  - decrypt_done rises on edge 706.
- Identity S, enc[0]=0x63 -> dec[0]=0x61.
  - With ABORT_ON_INVALID_EN, enc[1]=0x65 gives 0x60 -> invalid_flag=1 and decrypt_done=1 after 2 bytes; dec[2] is never written.
- S from a known key (00 02 49) KSA, enc from the course ROM -> all 32 dec bytes match the golden model; invalid_flag=0.
- start deasserted for 10 cycles mid-RD_SJ -> outputs frozen, no wren pulses; done is delayed by exactly 10 cycles and the data is unchanged.
- reset pulsed during byte 5 -> next cycle decrypt_done=0, state IDLE, i=j=k=0. A rerun from a freshly reloaded S produces correct output.
- Monitor across all tests -> s_wren and dec_wren are never high in the same cycle, and each is never high for 2 consecutive cycles except the WR_SI/WR_SJ pair.
